note_sequencer: RTL and testbench

- Song-track reader that drives the note-load side of note_player.
- Fetches 16-bit song words from a synchronous ROM (rom_sync-style, 1-cycle read latency) and decodes them into notes or control commands.
- Issues a one-cycle o_load with pitch/duration/instrument, then waits for note_player's o_done before fetching the next word.
- One instance per voice; sits between the song ROM and note_player.

---
 rtl/note_sequencer.sv | 117 +++++++++++
 tb/tb_note_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song-track reader for one voice: fetches words from a 1-cycle-latency ROM,
// decodes notes and control commands, and hands notes to note_player.
module note_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int MAX_CMDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_start_addr,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_load,
  output logic [5:0]        o_pitch,
  output logic [4:0]        o_duration,
  output logic [3:0]        o_instrument,
  input  logic              i_done,
  output logic              o_playing,
  output logic              o_finished,
  output logic              o_error
);

  localparam int CNT_W = $clog2(MAX_CMDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cmd_cnt;
  logic [CNT_W-1:0] cmd_next;
  logic             is_note;
  logic             is_end;
  logic             is_jump;
  logic             cmd_limit;

  assign is_note   = ~i_rom_data[15];
  assign is_end    = i_rom_data[15] & (i_rom_data[14:13] == 2'b00);
  assign is_jump   = i_rom_data[15] & (i_rom_data[14:13] == 2'b01);
  assign cmd_next  = cmd_cnt + CNT_W'(1);
  assign cmd_limit = (cmd_next == CNT_W'(MAX_CMDS));

  // Strobes default low every cycle; stop overrides everything but keeps address and note fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      cmd_cnt      <= '0;
      o_rom_addr   <= '0;
      o_pitch      <= '0;
      o_duration   <= '0;
      o_instrument <= '0;
      o_load       <= 1'b0;
      o_playing    <= 1'b0;
      o_finished   <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_load     <= 1'b0;
      o_finished <= 1'b0;
      o_error    <= 1'b0;
      if (i_stop) begin
        state     <= S_IDLE;
        o_playing <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              o_rom_addr <= i_start_addr;
              cmd_cnt    <= '0;
              state      <= S_WAIT;
              o_playing  <= 1'b1;
            end
          end
          S_WAIT: state <= S_DECODE;
          S_DECODE: begin
            if (is_note) begin
              o_pitch      <= i_rom_data[14:9];
              o_duration   <= i_rom_data[8:4];
              o_instrument <= i_rom_data[3:0];
              cmd_cnt      <= '0;
              o_load       <= 1'b1;
              state        <= S_LOAD;
            end else if (is_end) begin
              o_finished <= 1'b1;
              o_playing  <= 1'b0;
              state      <= S_IDLE;
            end else if (cmd_limit) begin
              // Too many commands in a row: abort without moving the address.
              cmd_cnt   <= cmd_next;
              o_error   <= 1'b1;
              o_playing <= 1'b0;
              state     <= S_IDLE;
            end else begin
              cmd_cnt    <= cmd_next;
              o_rom_addr <= is_jump ? i_rom_data[ADDR_W-1:0] : o_rom_addr + ADDR_W'(1);
              state      <= S_WAIT;
            end
          end
          S_LOAD: state <= S_PLAY;
          S_PLAY: begin
            if (i_done) begin
              o_rom_addr <= o_rom_addr + ADDR_W'(1);
              state      <= S_WAIT;
            end
          end
          default: begin
            state     <= S_IDLE;
            o_playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a bench-owned song ROM plus a
// word-walking reference model that predicts each load/finish/error event.
module tb_note_sequencer;

  localparam int ADDR_W   = 8;
  localparam int MAX_CMDS = 4;
  localparam int K_LOAD   = 0;
  localparam int K_FIN    = 1;
  localparam int K_ERR    = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_done = 1'b0;
  logic [7:0]  i_start_addr = 8'd0;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic        o_load;
  logic [5:0]  o_pitch;
  logic [4:0]  o_duration;
  logic [3:0]  o_instrument;
  logic        o_playing;
  logic        o_finished;
  logic        o_error;

  logic [15:0] rom [256];
  int vectors = 0;
  int miscompares = 0;

  note_sequencer #(.ADDR_W(ADDR_W), .MAX_CMDS(MAX_CMDS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_start_addr(i_start_addr), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_load(o_load), .o_pitch(o_pitch), .o_duration(o_duration),
    .o_instrument(o_instrument), .i_done(i_done), .o_playing(o_playing),
    .o_finished(o_finished), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  function automatic logic [15:0] mk_note(input int p, input int d, input int n);
    return {1'b0, 6'(p), 5'(d), 4'(n)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h8000;
  endtask

  // Walk the song from an address the way the word format describes; report the
  // terminating word, its address and how many commands preceded it.
  task automatic model_walk(input logic [7:0] from, output int kind, output int cmds_before,
                            output logic [7:0] at_addr, output logic [15:0] word);
    logic [7:0] a;
    int cmds;
    a = from; cmds = 0; kind = K_ERR; cmds_before = 0; at_addr = from; word = 16'h0;
    for (int step = 0; step < MAX_CMDS; step++) begin
      word = rom[a];
      at_addr = a;
      if (!word[15]) begin kind = K_LOAD; cmds_before = cmds; return; end
      if (word[14:13] == 2'b00) begin kind = K_FIN; cmds_before = cmds; return; end
      cmds++;
      if (cmds == MAX_CMDS) begin kind = K_ERR; cmds_before = cmds - 1; return; end
      a = (word[14:13] == 2'b01) ? word[7:0] : a + 8'd1;
    end
  endtask

  task automatic fire_start(input logic [7:0] a);
    @(negedge i_clk);
    i_start = 1'b1; i_start_addr = a;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic fire_done(input int d);
    repeat (d) @(negedge i_clk);
    i_done = 1'b1;
    @(posedge i_clk);
    #1 i_done = 1'b0;
  endtask

  task automatic fire_stop();
    @(negedge i_clk);
    i_stop = 1'b1;
    @(posedge i_clk);
    #1 i_stop = 1'b0;
  endtask

  // Called right after the triggering edge; watches for the model's next event.
  task automatic observe_step(input logic [7:0] from, input string tag,
                              output int kind, output logic [7:0] at_addr);
    int cmds, exp_c, got_c;
    logic [15:0] w;
    logic [2:0] exp_pulse;
    logic exp_play;
    model_walk(from, kind, cmds, at_addr, w);
    exp_c = 3 + 2 * cmds;
    got_c = 0;
    exp_pulse = (kind == K_LOAD) ? 3'b100 : (kind == K_FIN) ? 3'b010 : 3'b001;
    exp_play = (kind == K_LOAD);
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (o_load || o_finished || o_error) begin got_c = c; break; end
    end
    vectors++;
    if (got_c !== exp_c) begin
      miscompares++;
      $display("FAIL %s latency: event in cycle %0d, expected cycle %0d", tag, got_c, exp_c);
    end
    if (got_c != 0) begin
      vectors++;
      if ({o_load, o_finished, o_error} !== exp_pulse) begin
        miscompares++;
        $display("FAIL %s pulse: load/fin/err=%b, expected %b", tag, {o_load, o_finished, o_error}, exp_pulse);
      end
      vectors++;
      if (o_rom_addr !== at_addr) begin
        miscompares++;
        $display("FAIL %s addr: o_rom_addr=%h, expected %h", tag, o_rom_addr, at_addr);
      end
      vectors++;
      if (o_playing !== exp_play) begin
        miscompares++;
        $display("FAIL %s playing: o_playing=%b, expected %b", tag, o_playing, exp_play);
      end
      if (kind == K_LOAD) begin
        vectors++;
        if ({o_pitch, o_duration, o_instrument} !== w[14:0]) begin
          miscompares++;
          $display("FAIL %s fields: p/d/i=%0d/%0d/%0d, expected %0d/%0d/%0d", tag,
                   o_pitch, o_duration, o_instrument, w[14:9], w[8:4], w[3:0]);
        end
      end
      @(negedge i_clk);
      vectors++;
      if ({o_load, o_finished, o_error} !== 3'b000) begin
        miscompares++;
        $display("FAIL %s width: strobes=%b one cycle later, expected 000", tag, {o_load, o_finished, o_error});
      end
    end
  endtask

  task automatic test_reset();
    clear_rom();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    vectors++;
    if ({o_rom_addr, o_pitch, o_duration, o_instrument, o_load, o_playing, o_finished, o_error} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_values: outputs=%h, expected 0",
               {o_rom_addr, o_pitch, o_duration, o_instrument, o_load, o_playing, o_finished, o_error});
    end
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_playing, o_load} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: playing/load=%b, expected 00", {o_playing, o_load});
    end
  endtask

  task automatic test_single_note();
    int k;
    logic [7:0] a;
    clear_rom();
    rom[8'h10] = 16'h2A53;
    rom[8'h11] = 16'h8000;
    fire_start(8'h10);
    observe_step(8'h10, "single_load", k, a);
    vectors++;
    if ({o_pitch, o_duration, o_instrument} !== {6'd21, 5'd5, 4'd3}) begin
      miscompares++;
      $display("FAIL single_decode: p/d/i=%0d/%0d/%0d, expected 21/5/3", o_pitch, o_duration, o_instrument);
    end
    fire_done(4);
    observe_step(a + 8'd1, "single_end", k, a);
  endtask

  task automatic test_jump_loop();
    int k;
    logic [7:0] a;
    clear_rom();
    rom[0] = mk_note(40, 17, 9);
    rom[1] = 16'hA000;
    fire_start(8'h00);
    observe_step(8'h00, "loop_first", k, a);
    for (int i = 0; i < 3; i++) begin
      fire_done($urandom_range(0, 4));
      observe_step(a + 8'd1, "loop_iter", k, a);
    end
    fire_stop();
  endtask

  task automatic test_cmd_flood();
    int k;
    logic [7:0] a;
    clear_rom();
    for (int i = 5; i < 9; i++) rom[i] = 16'hC000 | 16'(i);
    fire_start(8'h05);
    observe_step(8'h05, "flood_error", k, a);
  endtask

  task automatic test_addr_wrap();
    int k;
    logic [7:0] a;
    clear_rom();
    rom[8'hFF] = mk_note(63, 31, 15);
    rom[8'h00] = 16'h8000;
    fire_start(8'hFF);
    observe_step(8'hFF, "wrap_load", k, a);
    fire_done(2);
    observe_step(a + 8'd1, "wrap_end", k, a);
  endtask

  task automatic test_stop_play();
    int k;
    logic [7:0] a;
    logic seen;
    clear_rom();
    rom[8'h30] = mk_note(12, 3, 7);
    rom[8'h31] = mk_note(50, 9, 2);
    fire_start(8'h30);
    observe_step(8'h30, "stop_load", k, a);
    fire_stop();
    @(negedge i_clk);
    vectors++;
    if ({o_playing, o_load, o_rom_addr, o_pitch, o_duration, o_instrument} !== {2'b00, 8'h30, rom[8'h30][14:0]}) begin
      miscompares++;
      $display("FAIL stop_hold: playing/load/addr/fields=%h, expected %h",
               {o_playing, o_load, o_rom_addr, o_pitch, o_duration, o_instrument},
               {2'b00, 8'h30, rom[8'h30][14:0]});
    end
    fire_done(0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      seen = seen | o_load | o_playing;
    end
    vectors++;
    if ({seen, o_rom_addr} !== {1'b0, 8'h30}) begin
      miscompares++;
      $display("FAIL stop_no_fetch: activity/addr=%h, expected %h", {seen, o_rom_addr}, {1'b0, 8'h30});
    end
  endtask

  task automatic test_start_stop_idle();
    logic seen;
    clear_rom();
    rom[8'h40] = mk_note(1, 1, 1);
    @(negedge i_clk);
    i_start = 1'b1; i_stop = 1'b1; i_start_addr = 8'h40;
    @(posedge i_clk);
    #1 i_start = 1'b0; i_stop = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      seen = seen | o_load | o_playing;
    end
    vectors++;
    if ({seen, o_rom_addr} !== {1'b0, 8'h30}) begin
      miscompares++;
      $display("FAIL start_stop_idle: activity/addr=%h, expected %h", {seen, o_rom_addr}, {1'b0, 8'h30});
    end
  endtask

  task automatic test_done_during_load();
    int k, load_c;
    logic [7:0] a;
    logic seen;
    clear_rom();
    rom[8'h20] = mk_note(33, 20, 4);
    rom[8'h21] = 16'h8000;
    fire_start(8'h20);
    i_done = 1'b1;
    load_c = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge i_clk);
      if (o_load) load_c = c;
      @(posedge i_clk);
    end
    #1 i_done = 1'b0;
    vectors++;
    if (load_c !== 3) begin
      miscompares++;
      $display("FAIL done_load_timing: load in cycle %0d, expected 3", load_c);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      seen = seen | o_load | o_finished | ~o_playing;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL done_in_load_ignored: activity=%b, expected 0", seen);
    end
    fire_done(0);
    observe_step(8'h21, "done_load_end", k, a);
  endtask

  task automatic test_reset_mid_wait();
    int k;
    logic [7:0] a;
    logic seen;
    clear_rom();
    rom[8'h50] = mk_note(7, 30, 11);
    fire_start(8'h50);
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_rom_addr, o_pitch, o_duration, o_instrument, o_load, o_playing, o_finished, o_error} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_async: outputs=%h, expected 0",
               {o_rom_addr, o_pitch, o_duration, o_instrument, o_load, o_playing, o_finished, o_error});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      seen = seen | o_load | o_playing;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: activity=%b, expected 0", seen);
    end
    fire_start(8'h50);
    observe_step(8'h50, "reset_restart", k, a);
    fire_stop();
  endtask

  task automatic test_random();
    int k, r, notes;
    logic [7:0] a, at;
    logic [15:0] w;
    for (int prog = 0; prog < 20; prog++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 55) w[15] = 1'b0;
        else if (r < 65) w[15:13] = 3'b100;
        else if (r < 80) w[15:13] = 3'b101;
        else w[15:14] = 2'b11;
        rom[i] = w;
      end
      a = 8'($urandom);
      fire_start(a);
      notes = 0;
      forever begin
        observe_step(a, "random", k, at);
        if (k != K_LOAD) break;
        notes++;
        if (notes == 5) begin
          fire_stop();
          @(negedge i_clk);
          vectors++;
          if (o_playing !== 1'b0) begin
            miscompares++;
            $display("FAIL random_stop: o_playing=%b, expected 0", o_playing);
          end
          break;
        end
        fire_done($urandom_range(0, 5));
        a = at + 8'd1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_single_note();
    test_jump_loop();
    test_cmd_flood();
    test_addr_wrap();
    test_stop_play();
    test_start_stop_idle();
    test_done_during_load();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
